travel_step_tracker: RTL and testbench

//  Consumes the per-step Trvl/FwdBck outputs of the quadrature encoder top.

---
 rtl/travel_step_tracker.sv | 168 ++++++++++++++++
 tb/tb_travel_step_tracker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/travel_step_tracker.sv
// ============================================================================
//  Module      : travel_step_tracker
//  Description : Signed step position, step period, stall, reversal and soft
//                limit tracking downstream of the quadrature encoder top.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module travel_step_tracker #(
   parameter int POS_BITS     = 16,
   parameter int PER_BITS     = 24,
   parameter int STALL_CYCLES = 5000000,
   parameter int LIM_HI       = 1000,
   parameter int LIM_LO       = -1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                trvl,
   input  logic                fwd_bck,
   input  logic                clr,
   output logic [POS_BITS-1:0] position,
   output logic [PER_BITS-1:0] period,
   output logic                period_valid,
   output logic                dir,
   output logic                dir_change,
   output logic                moving,
   output logic                stall,
   output logic                limit_hi,
   output logic                limit_lo
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_TRACK = 2'd2
   } state_t;

   localparam logic [PER_BITS-1:0] c_GAP_MAX = '1;
   localparam logic [PER_BITS-1:0] c_STALL   = PER_BITS'(STALL_CYCLES);
   localparam logic [POS_BITS-1:0] c_POS_MAX = {1'b0, {(POS_BITS-1){1'b1}}};
   localparam logic [POS_BITS-1:0] c_POS_MIN = {1'b1, {(POS_BITS-1){1'b0}}};

   state_t              r_state;
   state_t              w_state_nx;
   logic                r_trvl_q;
   logic [PER_BITS-1:0] r_gap;
   logic [POS_BITS-1:0] r_position;
   logic [PER_BITS-1:0] r_period;
   logic                r_period_valid;
   logic                r_dir;
   logic                r_dir_change;
   logic                r_moving;
   logic                r_stall;
   logic                r_limit_hi;
   logic                r_limit_lo;

   logic                w_step;
   logic [PER_BITS-1:0] w_gap_inc;
   logic                w_timeout;
   logic [POS_BITS-1:0] w_pos_nx;
   logic signed [31:0]  w_pos_ext;
   logic [PER_BITS-1:0] w_period_nx;
   logic                w_period_valid_nx;
   logic                w_dir_nx;
   logic                w_dir_change_nx;
   logic                w_stall_nx;

   // Period is the cycle count from one step edge to the next, hence gap+1
   always_comb begin
      w_step    = trvl & ~r_trvl_q;
      w_gap_inc = (r_gap == c_GAP_MAX) ? r_gap : r_gap + 1'b1;
      w_timeout = (w_gap_inc >= c_STALL);
   end

   always_comb begin
      w_state_nx        = r_state;
      w_period_nx       = r_period;
      w_period_valid_nx = 1'b0;
      w_dir_nx          = r_dir;
      w_dir_change_nx   = 1'b0;
      w_stall_nx        = r_stall;
      case (r_state)
         S_IDLE: begin
            if (w_step) begin
               w_state_nx = S_ARMED;
               w_stall_nx = 1'b0;
               w_dir_nx   = fwd_bck;
            end
         end
         S_ARMED, S_TRACK: begin
            if (w_step) begin
               w_stall_nx = 1'b0;
               if (fwd_bck == r_dir) begin
                  w_state_nx        = S_TRACK;
                  w_period_nx       = w_gap_inc;
                  w_period_valid_nx = 1'b1;
               end else begin
                  w_state_nx      = S_ARMED;
                  w_dir_nx        = fwd_bck;
                  w_dir_change_nx = 1'b1;
               end
            end else if (w_timeout) begin
               w_state_nx = S_IDLE;
               w_stall_nx = 1'b1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // clr overrides the increment but the step still drives the FSM above
   always_comb begin
      w_pos_nx = r_position;
      if (clr) begin
         w_pos_nx = '0;
      end else if (w_step) begin
         if (fwd_bck && (r_position != c_POS_MAX)) begin
            w_pos_nx = r_position + 1'b1;
         end else if (!fwd_bck && (r_position != c_POS_MIN)) begin
            w_pos_nx = r_position - 1'b1;
         end
      end
      w_pos_ext = 32'($signed(w_pos_nx));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_trvl_q       <= 1'b1;
         r_gap          <= '0;
         r_position     <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
         r_dir          <= 1'b0;
         r_dir_change   <= 1'b0;
         r_moving       <= 1'b0;
         r_stall        <= 1'b0;
         r_limit_hi     <= (32'sd0 >= LIM_HI);
         r_limit_lo     <= (32'sd0 <= LIM_LO);
      end else begin
         r_state        <= w_state_nx;
         r_trvl_q       <= trvl;
         r_gap          <= w_step ? '0 : w_gap_inc;
         r_position     <= w_pos_nx;
         r_period       <= w_period_nx;
         r_period_valid <= w_period_valid_nx;
         r_dir          <= w_dir_nx;
         r_dir_change   <= w_dir_change_nx;
         r_moving       <= (w_state_nx != S_IDLE);
         r_stall        <= w_stall_nx;
         r_limit_hi     <= (w_pos_ext >= LIM_HI);
         r_limit_lo     <= (w_pos_ext <= LIM_LO);
      end
   end

   assign position     = r_position;
   assign period       = r_period;
   assign period_valid = r_period_valid;
   assign dir          = r_dir;
   assign dir_change   = r_dir_change;
   assign moving       = r_moving;
   assign stall        = r_stall;
   assign limit_hi     = r_limit_hi;
   assign limit_lo     = r_limit_lo;

endmodule

`default_nettype wire

// File: tb/tb_travel_step_tracker.sv
// ============================================================================
//  Module      : tb_travel_step_tracker
//  Description : Directed self-checking bench for travel_step_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_travel_step_tracker;

   localparam int c_STALL = 200;

   logic        clk = 1'b0;
   logic        reset;
   logic        trvl;
   logic        fwd_bck;
   logic        clr;

   logic [15:0] position;
   logic [23:0] period;
   logic        period_valid, dir, dir_change, moving, stall, limit_hi, limit_lo;

   logic [3:0]  position4;
   logic [23:0] period4;
   logic        period_valid4, dir4, dir_change4, moving4, stall4, limit_hi4, limit_lo4;

   int n_tests = 0;
   int n_fail  = 0;

   travel_step_tracker #(
      .POS_BITS(16), .PER_BITS(24), .STALL_CYCLES(c_STALL), .LIM_HI(1000), .LIM_LO(-1000)
   ) dut (
      .clk(clk), .reset(reset), .trvl(trvl), .fwd_bck(fwd_bck), .clr(clr),
      .position(position), .period(period), .period_valid(period_valid),
      .dir(dir), .dir_change(dir_change), .moving(moving), .stall(stall),
      .limit_hi(limit_hi), .limit_lo(limit_lo)
   );

   travel_step_tracker #(
      .POS_BITS(4), .PER_BITS(24), .STALL_CYCLES(c_STALL), .LIM_HI(6), .LIM_LO(-6)
   ) dut4 (
      .clk(clk), .reset(reset), .trvl(trvl), .fwd_bck(fwd_bck), .clr(clr),
      .position(position4), .period(period4), .period_valid(period_valid4),
      .dir(dir4), .dir_change(dir_change4), .moving(moving4), .stall(stall4),
      .limit_hi(limit_hi4), .limit_lo(limit_lo4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle strobe; the posedge inside this task samples the step
   task automatic step(input logic fwd);
      trvl    = 1'b1;
      fwd_bck = fwd;
      @(negedge clk);
      trvl    = 1'b0;
   endtask

   // Step landing n cycles after the previous step (n >= 2)
   task automatic stepn(input logic fwd, input int n);
      idle(n - 1);
      step(fwd);
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset = 1'b0;
      trvl  = 1'b0;
      clr   = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      idle(2);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; trvl = 1'b0; fwd_bck = 1'b0; clr = 1'b0;
      idle(3);
      chk("rst_pos",    $signed(position), 0);
      chk("rst_period", period, 0);
      chk("rst_pv",     period_valid, 0);
      chk("rst_moving", moving, 0);
      chk("rst_stall",  stall, 0);
      chk("rst_dir",    dir, 0);
      chk("rst_lim_hi", limit_hi, 0);
      chk("rst_lim_lo", limit_lo, 0);
      reset = 1'b1;
      idle(5);

      // forward tracking at a 100-cycle pitch
      step(1'b1);
      chk("t1_pos1",   $signed(position), 1);
      chk("t1_moving", moving, 1);
      chk("t1_dir",    dir, 1);
      chk("t1_pv1",    period_valid, 0);
      stepn(1'b1, 100);
      chk("t1_pos2",   $signed(position), 2);
      chk("t1_per2",   period, 100);
      chk("t1_pv2",    period_valid, 1);
      stepn(1'b1, 100);
      chk("t1_pos3",   $signed(position), 3);
      chk("t1_per3",   period, 100);
      chk("t1_pv3",    period_valid, 1);
      idle(1);
      chk("t1_pv_drop", period_valid, 0);

      // reversal
      do_reset;
      step(1'b1);
      stepn(1'b1, 50);
      chk("t2_per50", period, 50);
      stepn(1'b0, 30);
      chk("t2_dc",     dir_change, 1);
      chk("t2_dir",    dir, 0);
      chk("t2_pos",    $signed(position), 1);
      chk("t2_perhold", period, 50);
      chk("t2_pv",     period_valid, 0);
      idle(1);
      chk("t2_dc_drop", dir_change, 0);
      stepn(1'b0, 39);  // 40 cycles after the reversal step
      chk("t2_per40",  period, 40);
      chk("t2_pv40",   period_valid, 1);
      chk("t2_pos0",   $signed(position), 0);

      // stall timeout, then a step landing exactly on the timeout cycle
      do_reset;
      step(1'b1);
      idle(c_STALL - 1);
      chk("t3_nostall", stall, 0);
      chk("t3_moving",  moving, 1);
      idle(1);
      chk("t3_stall",   stall, 1);
      chk("t3_stopped", moving, 0);
      step(1'b1);
      chk("t3_unstall", stall, 0);
      chk("t3_rearm",   moving, 1);
      chk("t3_pv",      period_valid, 0);
      stepn(1'b1, c_STALL);
      chk("t3_edge_stall", stall, 0);
      chk("t3_edge_move",  moving, 1);
      chk("t3_edge_per",   period, c_STALL);
      chk("t3_edge_pv",    period_valid, 1);

      // saturation, clr priority, low limit on the 4-bit instance
      do_reset;
      for (int i = 0; i < 9; i++) stepn(1'b1, 2);
      chk("t4_sat_hi",  $signed(position4), 7);
      chk("t4_lim_hi4", limit_hi4, 1);
      chk("t4_pos16",   $signed(position), 9);
      idle(1);
      clr = 1'b1;
      step(1'b0);
      clr = 1'b0;
      chk("t4_clr_pos", $signed(position4), 0);
      chk("t4_clr_dir", dir4, 0);
      chk("t4_clr_dc",  dir_change4, 1);
      chk("t4_clr_p16", $signed(position), 0);
      for (int i = 0; i < 9; i++) stepn(1'b0, 2);
      chk("t4_sat_lo",  $signed(position4), -8);
      chk("t4_lim_lo4", limit_lo4, 1);
      chk("t4_lo_p16",  $signed(position), -9);

      // soft upper limit and mid-run reset with trvl held high
      do_reset;
      for (int i = 0; i < 999; i++) stepn(1'b1, 2);
      chk("t5_pos999", $signed(position), 999);
      chk("t5_lim0",   limit_hi, 0);
      stepn(1'b1, 2);
      chk("t5_pos1000", $signed(position), 1000);
      chk("t5_lim1",    limit_hi, 1);
      idle(1);
      reset   = 1'b0;
      trvl    = 1'b1;
      fwd_bck = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      chk("t5_rst_pos",    $signed(position), 0);
      chk("t5_rst_period", period, 0);
      chk("t5_rst_moving", moving, 0);
      chk("t5_rst_lim",    limit_hi, 0);
      chk("t5_rst_dir",    dir, 0);
      idle(2);
      chk("t5_held_pos",    $signed(position), 0);
      chk("t5_held_moving", moving, 0);
      trvl = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
